lcd_nibble_driver: RTL and testbench

//  Physical-layer driver for the LCD 1602A in 4-bit mode, directly downstream of the LCD control FSM.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_delay_counter.sv | 28 ++
 rtl/lcd_nibble_driver.sv | 174 +++++++++++++++++
 tb/tb_lcd_nibble_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD 1602A path: FSM encoding, register-select
// values, default HD44780 timing in 50 MHz clock cycles and command bytes.
package lcd_pkg;

    // One-hot driver state encoding (9 states)
    typedef enum logic [8:0] {
        ST_IDLE     = 9'b000000001,
        ST_SETUP_HI = 9'b000000010,
        ST_EN_HI    = 9'b000000100,
        ST_GAP      = 9'b000001000,
        ST_SETUP_LO = 9'b000010000,
        ST_EN_LO    = 9'b000100000,
        ST_EXEC     = 9'b001000000,
        ST_DONE     = 9'b010000000,
        ST_RELEASE  = 9'b100000000
    } drv_state_e;

    // Register select values
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // Default timing (cycles at 50 MHz)
    localparam int T_SETUP_DEF = 2;     // address setup before E rises
    localparam int T_EN_DEF    = 13;    // E pulse width
    localparam int T_GAP_DEF   = 50;    // E low between nibbles
    localparam int T_EXEC_DEF  = 2100;  // short-instruction execution time
    localparam int CNT_W_DEF   = 12;

    // Command bytes used by the controller
    localparam logic [7:0] SETUP      = 8'h28;  // 4-bit, 2 lines, 5x8
    localparam logic [7:0] ENTRY_MODE = 8'h06;  // increment, no shift
    localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CLEAR_CMD  = 8'h01;  // clear display
    localparam logic [7:0] HOME_CMD   = 8'h02;  // return home

    // Nibble helpers
    function automatic logic [3:0] hi_nibble(input logic [7:0] b);
        return b[7:4];
    endfunction

    function automatic logic [3:0] lo_nibble(input logic [7:0] b);
        return b[3:0];
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counter that times each driver state. Loading T-1 on state entry
// and leaving the state when zero is reached gives exactly T cycles.
module lcd_delay_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit physical-layer driver: sends one byte per request as a
// high/low nibble pair with setup, enable-width, gap and execution timing,
// then pulses driver_rdy. Pins are registered from next-state decode so
// they change cleanly on clock edges.
module lcd_nibble_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP_CYC = T_SETUP_DEF,
    parameter int T_EN_CYC    = T_EN_DEF,
    parameter int T_GAP_CYC   = T_GAP_DEF,
    parameter int T_EXEC_CYC  = T_EXEC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drv_enable,
    input  logic [7:0] drv_data,
    input  logic       drv_rs,
    output logic       driver_rdy,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);

    drv_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    logic             e_q, e_d;
    logic             rs_pin_q, rs_pin_d;
    logic [3:0]       db_q, db_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;

    lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // State, latched byte and pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            rs_pin_q <= 1'b0;
            db_q     <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
            rs_pin_q <= rs_pin_d;
            db_q     <= db_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    // Next-state sequencing with counter loads, plus pin decode of the next state
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rs_d     = rs_q;
        cnt_load = 1'b0;
        cnt_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (drv_enable) begin
                    state_d  = ST_SETUP_HI;
                    data_d   = drv_data;
                    rs_d     = drv_rs;
                    cnt_load = 1'b1;
                    cnt_val  = LD_SETUP;
                end
            end
            ST_SETUP_HI: begin
                if (cnt_zero) begin
                    state_d  = ST_EN_HI;
                    cnt_load = 1'b1;
                    cnt_val  = LD_EN;
                end
            end
            ST_EN_HI: begin
                if (cnt_zero) begin
                    state_d  = ST_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = LD_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d  = ST_SETUP_LO;
                    cnt_load = 1'b1;
                    cnt_val  = LD_SETUP;
                end
            end
            ST_SETUP_LO: begin
                if (cnt_zero) begin
                    state_d  = ST_EN_LO;
                    cnt_load = 1'b1;
                    cnt_val  = LD_EN;
                end
            end
            ST_EN_LO: begin
                if (cnt_zero) begin
                    state_d  = ST_EXEC;
                    cnt_load = 1'b1;
                    cnt_val  = LD_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A held enable must not start a second transfer
                if (!drv_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        e_d      = (state_d == ST_EN_HI) || (state_d == ST_EN_LO);
        busy_d   = (state_d != ST_IDLE);
        rdy_d    = (state_d == ST_DONE);
        rs_pin_d = (state_d != ST_IDLE) ? rs_d : 1'b0;
        case (state_d)
            ST_SETUP_HI, ST_EN_HI, ST_GAP:                    db_d = hi_nibble(data_d);
            ST_SETUP_LO, ST_EN_LO, ST_EXEC, ST_DONE, ST_RELEASE: db_d = lo_nibble(data_d);
            default:                                          db_d = 4'h0;
        endcase
    end

    // A zero-length timed state or a counter too narrow would break the timing
    always @(posedge clk) begin
        assert (T_SETUP_CYC > 0 && T_EN_CYC > 0 && T_GAP_CYC > 0 && T_EXEC_CYC > 0)
            else $error("lcd_nibble_driver: timing parameter of zero cycles");
        assert (T_EXEC_CYC - 1 < (1 << CNT_W) && T_GAP_CYC - 1 < (1 << CNT_W))
            else $error("lcd_nibble_driver: CNT_W too narrow for timing parameters");
    end

    assign driver_rdy = rdy_q;
    assign busy       = busy_q;
    assign lcd_e      = e_q;
    assign lcd_rs     = rs_pin_q;
    assign lcd_rw     = 1'b0;
    assign lcd_db     = db_q;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Scoreboard bench for lcd_nibble_driver: the stimulus thread queues the
// expected nibble pair and RS for each transfer; a monitor reconstructs
// what the pins showed and checks it when driver_rdy pulses.
module tb_lcd_nibble_driver;

    localparam int EXP_LAT   = 2181;  // 1 + 2*2 + 2*13 + 50 + 2100
    localparam int EXP_EWIDE = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_enable = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_rs = 1'b0;
    logic       driver_rdy, busy, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_db;

    lcd_nibble_driver dut (
        .clk        (clk),
        .rst        (rst),
        .drv_enable (drv_enable),
        .drv_data   (drv_data),
        .drv_rs     (drv_rs),
        .driver_rdy (driver_rdy),
        .busy       (busy),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_db     (lcd_db)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       rs;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor state
    logic       e_prev = 1'b0, busy_prev = 1'b0;
    int         idx = 0, width = 0, accept_cyc = 0;
    logic [3:0] nib[2];
    logic       rs_cap[2];
    int         w_cap[2];
    logic       hold_err = 1'b0, rw_err = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            e_prev = 1'b0; busy_prev = 1'b0; idx = 0; width = 0;
        end else begin
            if (busy && !busy_prev) begin
                accept_cyc = cyc; idx = 0; hold_err = 1'b0; rw_err = 1'b0;
            end
            if (lcd_rw) rw_err = 1'b1;
            if (lcd_e && !e_prev) begin
                if (idx < 2) begin nib[idx] = lcd_db; rs_cap[idx] = lcd_rs; end
                width = 1;
            end else if (lcd_e) begin
                width++;
                if (idx < 2 && (lcd_db != nib[idx] || lcd_rs != rs_cap[idx])) hold_err = 1'b1;
            end else if (e_prev) begin
                if (idx < 2) w_cap[idx] = width;
                idx++;
            end
            if (driver_rdy) begin
                exp_t e;
                rdy_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rdy", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("e_pulse_count", idx, 2);
                    chk("hi_nibble", nib[0], e.hi);
                    chk("lo_nibble", nib[1], e.lo);
                    chk("rs_hi", rs_cap[0], e.rs);
                    chk("rs_lo", rs_cap[1], e.rs);
                    chk("e_width_hi", w_cap[0], EXP_EWIDE);
                    chk("e_width_lo", w_cap[1], EXP_EWIDE);
                    chk("rdy_latency", cyc + 1 - accept_cyc, EXP_LAT);
                    chk("pins_held_during_e", hold_err, 0);
                    chk("rw_low", rw_err, 0);
                    $display("xfer rs=%0d nibbles %h,%h latency %0d", e.rs, nib[0], nib[1], cyc + 1 - accept_cyc);
                end
            end
            e_prev = lcd_e;
            busy_prev = busy;
        end
    end

    task automatic wait_rdy(input int start);
        int n;
        n = 0;
        while (rdy_count == start && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (rdy_count == start) chk("rdy_timeout", 0, 1);
    endtask

    // One transfer: optional enable drop, optional data change, optional hold
    task automatic send(input logic [7:0] b, input logic rs, input int drop_at,
                        input int chg_at, input int hold);
        exp_t e;
        int start;
        e.hi = b[7:4]; e.lo = b[3:0]; e.rs = rs;
        exp_q.push_back(e);
        start = rdy_count;
        @(posedge clk); #1;
        drv_data = b; drv_rs = rs; drv_enable = 1'b1;
        if (chg_at > 0) begin
            repeat (chg_at) @(posedge clk);
            #1 drv_data = 8'hFF; drv_rs = ~rs;
        end
        if (drop_at > 0) begin
            repeat (drop_at) @(posedge clk);
            #1 drv_enable = 1'b0;
        end
        wait_rdy(start);
        @(posedge clk); #1;
        chk("busy_in_release", busy, 1);
        chk("rdy_one_cycle", driver_rdy, 0);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("busy_while_held", busy, 1);
            chk("lcd_e_low_while_held", lcd_e, 0);
        end
        chk("single_rdy", rdy_count - start, 1);
        drv_enable = 1'b0;
        @(posedge clk); #1;
        chk("busy_idle", busy, 0);
        chk("db_idle", lcd_db, 0);
        chk("rs_idle", lcd_rs, 0);
    endtask

    initial begin
        int start;
        // Reset state
        #23;
        chk("rst_rdy", driver_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset while E is high in the first nibble
        start = rdy_count;
        #1 drv_data = 8'h28; drv_rs = 1'b0; drv_enable = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("e_high_before_rst", lcd_e, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_e", lcd_e, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_rdy", driver_rdy, 0);
        drv_enable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2500) @(posedge clk);
        #1 chk("no_rdy_after_rst", rdy_count - start, 0);
        $display("reset mid-EN_HI checked");

        // Command 0x28, enable held until completion
        send(8'h28, 1'b0, 0, 0, 0);
        // Data 0x41 with enable held for 5000 cycles
        send(8'h41, 1'b1, 0, 0, 5000);
        // Enable dropped at cycle 20 of clear command
        send(8'h01, 1'b0, 20, 0, 0);
        // Inputs change after accept
        send(8'h0C, 1'b0, 0, 5, 0);
        // Init sequence back to back
        send(8'h28, 1'b0, 0, 0, 0);
        send(8'h06, 1'b0, 0, 0, 0);
        send(8'h0C, 1'b0, 0, 0, 0);
        send(8'h01, 1'b0, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
